interval_gen: RTL and testbench

- Initiator side of the start/stop measurement interface: drives one-cycle start and stop strobes separated by a programmed number of clock cycles.
- A downstream start-to-stop cycle counter therefore reads exactly the programmed duration.
- Supports single-shot, N-repeat and free-running interval trains, plus abort.
- Sits beside the stopwatch counters; configured by the host control logic through a valid/ready handshake.

---
 rtl/interval_pkg.sv | 21 ++
 rtl/interval_down_counter.sv | 36 +++
 rtl/interval_gen.sv | 181 ++++++++++++++++++
 tb/tb_interval_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : interval_pkg
//  Description : Shared state encoding and constants for the interval generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package interval_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        RUN      = 3'd2,
        GAP_WAIT = 3'd3,
        FINISH   = 3'd4
    } state_t;

    // Durations below this are promoted so every start is paired with a later stop.
    localparam int unsigned c_MIN_DURATION = 1;

endpackage
`default_nettype wire

// File: rtl/interval_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : interval_down_counter
//  Description : Loadable down counter with zero flag; saturates at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module interval_down_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Load wins over decrement; decrement never wraps past zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/interval_gen.sv
`default_nettype none
// ============================================================================
//  Module      : interval_gen
//  Description : Start/stop strobe initiator producing single, N-repeat or
//                free-running interval trains with abort support.
//  Revision    : 1.0 - initial release
// ============================================================================
module interval_gen
    import interval_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RPT_W = 16,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_duration,
    input  logic [RPT_W-1:0] cfg_repeat,
    input  logic             abort,
    output logic             start,
    output logic             stop,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [RPT_W-1:0] interval_idx,
    output logic [WIDTH-1:0] remaining
);

    // The stop cycle counts as the first gap cycle, so GAP_WAIT lasts GAP-1 cycles.
    localparam logic [WIDTH-1:0] c_GAP_LOAD = WIDTH'((GAP > 1) ? (GAP - 2) : 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_dur;
    logic [RPT_W-1:0] r_rpt;
    logic [RPT_W-1:0] r_idx;
    logic             r_aborted;

    logic             w_accept;
    logic             w_idx_inc;
    logic             w_set_abort;
    logic             w_load;
    logic [WIDTH-1:0] w_load_val;
    logic             w_dec;
    logic [WIDTH-1:0] w_count;
    logic             w_zero;
    logic [WIDTH-1:0] w_dur_in;
    logic             w_last;

    assign w_dur_in = (cfg_duration < WIDTH'(c_MIN_DURATION)) ? WIDTH'(c_MIN_DURATION)
                                                              : cfg_duration;
    assign w_last   = (r_rpt != '0) && (r_idx == (r_rpt - RPT_W'(1)));

    interval_down_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_dec),
        .count    (w_count),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_dur     <= '0;
            r_rpt     <= '0;
            r_idx     <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_dur     <= w_dur_in;
                r_rpt     <= cfg_repeat;
                r_idx     <= '0;
                r_aborted <= 1'b0;
            end else begin
                if (w_idx_inc) begin
                    r_idx <= r_idx + RPT_W'(1);
                end
                if (w_set_abort) begin
                    r_aborted <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_idx_inc   = 1'b0;
        w_set_abort = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_dec       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        done        = 1'b0;

        case (r_state)
            IDLE: begin
                if (cfg_valid) begin
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = w_dur_in;
                    w_state_nxt = START;
                end
            end

            START: begin
                start       = 1'b1;
                w_dec       = 1'b1;
                w_state_nxt = RUN;
            end

            RUN: begin
                if (w_zero) begin
                    stop = 1'b1;
                    if (abort) begin
                        w_set_abort = 1'b1;
                    end
                    if (abort || r_aborted || w_last) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_idx_inc = 1'b1;
                        w_load    = 1'b1;
                        if (GAP > 1) begin
                            w_load_val  = c_GAP_LOAD;
                            w_state_nxt = GAP_WAIT;
                        end else begin
                            w_load_val  = r_dur;
                            w_state_nxt = START;
                        end
                    end
                end else if (abort) begin
                    // Forcing the counter to zero makes the stop land on the next cycle.
                    w_set_abort = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = '0;
                end else begin
                    w_dec = 1'b1;
                end
            end

            GAP_WAIT: begin
                if (abort) begin
                    w_set_abort = 1'b1;
                    w_state_nxt = FINISH;
                end else if (w_zero) begin
                    w_load      = 1'b1;
                    w_load_val  = r_dur;
                    w_state_nxt = START;
                end else begin
                    w_dec = 1'b1;
                end
            end

            FINISH: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign cfg_ready    = (r_state == IDLE);
    assign busy         = (r_state == START) || (r_state == RUN) || (r_state == GAP_WAIT);
    assign aborted      = r_aborted;
    assign interval_idx = r_idx;
    assign remaining    = w_count;

endmodule
`default_nettype wire

// File: tb/tb_interval_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interval_gen
//  Description : Scoreboard bench for interval_gen strobe timing and abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_gen;

    localparam int c_K_START = 0;
    localparam int c_K_STOP  = 1;
    localparam int c_K_DONE  = 2;

    typedef struct {
        int kind;
        int cyc;
        int idx;
        int ab;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_duration = '0;
    logic [15:0] cfg_repeat = '0;
    logic        abort = 1'b0;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] interval_idx;
    logic [31:0] remaining;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  sb[$];

    interval_gen #(
        .WIDTH (32),
        .RPT_W (16),
        .GAP   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_duration (cfg_duration),
        .cfg_repeat   (cfg_repeat),
        .abort        (abort),
        .start        (start),
        .stop         (stop),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .interval_idx (interval_idx),
        .remaining    (remaining)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int idx, input int ab);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.idx  = idx;
        e.ab   = ab;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe: got kind=%0d at cycle %0d required no strobe", kind, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.idx != int'(interval_idx) ||
                (kind == c_K_DONE && e.ab != int'(aborted))) begin
                failures++;
                $display("FAIL strobe_event: got kind=%0d cycle=%0d idx=%0d ab=%0d required kind=%0d cycle=%0d idx=%0d ab=%0d",
                         kind, cyc, interval_idx, aborted, e.kind, e.cyc, e.idx, e.ab);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (start) check_ev(c_K_START);
            if (stop)  check_ev(c_K_STOP);
            if (done)  check_ev(c_K_DONE);
        end
    end

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic configure(input logic [31:0] d, input logic [15:0] r, output int a);
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cfg_ready_before_config", int'(cfg_ready), 1);
        a            = cyc;
        cfg_valid    = 1'b1;
        cfg_duration = d;
        cfg_repeat   = r;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || !cfg_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || !cfg_ready) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending events required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cfg_ready", int'(cfg_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_start", int'(start), 0);
        chk("reset_stop", int'(stop), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_aborted", int'(aborted), 0);
        chk("reset_idx", int'(interval_idx), 0);
        chk("reset_remaining", int'(remaining), 0);

        // Single shot D=5
        configure(32'd5, 16'd1, a);
        push(c_K_START, a + 1, 0, 0);
        push(c_K_STOP,  a + 6, 0, 0);
        push(c_K_DONE,  a + 7, 0, 0);
        wait_cycle(a + 1);
        chk("single_busy_at_start", int'(busy), 1);
        chk("single_remaining_at_start", int'(remaining), 5);
        wait_cycle(a + 3);
        chk("single_remaining_mid", int'(remaining), 3);
        wait_cycle(a + 6);
        chk("single_busy_at_stop", int'(busy), 1);
        chk("single_remaining_at_stop", int'(remaining), 0);
        wait_cycle(a + 7);
        chk("single_busy_at_done", int'(busy), 0);
        chk("single_ready_at_done", int'(cfg_ready), 0);
        wait_cycle(a + 8);
        chk("single_ready_after_done", int'(cfg_ready), 1);
        wait_idle("single");

        // Zero duration behaves as D=1
        configure(32'd0, 16'd1, a);
        push(c_K_START, a + 1, 0, 0);
        push(c_K_STOP,  a + 2, 0, 0);
        push(c_K_DONE,  a + 3, 0, 0);
        wait_idle("zero_dur");

        // Three intervals D=3, GAP=1
        configure(32'd3, 16'd3, a);
        push(c_K_START, a + 1,  0, 0);
        push(c_K_STOP,  a + 4,  0, 0);
        push(c_K_START, a + 5,  1, 0);
        push(c_K_STOP,  a + 8,  1, 0);
        push(c_K_START, a + 9,  2, 0);
        push(c_K_STOP,  a + 12, 2, 0);
        push(c_K_DONE,  a + 13, 2, 0);
        wait_idle("repeat");
        chk("repeat_idx_hold", int'(interval_idx), 2);

        // Free-running D=100, abort at start+7
        configure(32'd100, 16'd0, a);
        push(c_K_START, a + 1,  0, 0);
        push(c_K_STOP,  a + 9,  0, 1);
        push(c_K_DONE,  a + 10, 0, 1);
        wait_cycle(a + 8);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("abort_run");
        chk("abort_flag_hold", int'(aborted), 1);

        // Abort coincident with natural stop, D=4
        configure(32'd4, 16'd1, a);
        push(c_K_START, a + 1, 0, 0);
        push(c_K_STOP,  a + 5, 0, 0);
        push(c_K_DONE,  a + 6, 0, 1);
        wait_cycle(a + 1);
        chk("abort_cleared_on_accept", int'(aborted), 0);
        wait_cycle(a + 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("collision");

        // Abort during START is ignored
        configure(32'd2, 16'd1, a);
        push(c_K_START, a + 1, 0, 0);
        push(c_K_STOP,  a + 3, 0, 0);
        push(c_K_DONE,  a + 4, 0, 0);
        wait_cycle(a + 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("abort_in_start");

        // Reset two cycles after start
        configure(32'd10, 16'd1, a);
        push(c_K_START, a + 1, 0, 0);
        wait_cycle(a + 3);
        chk("pre_reset_remaining", int'(remaining), 8);
        rst = 1'b1;
        #1;
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_stop", int'(stop), 0);
        chk("mid_reset_remaining", int'(remaining), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", int'(cfg_ready), 1);
        chk("post_reset_pending", sb.size(), 0);
        configure(32'd2, 16'd1, a);
        push(c_K_START, a + 1, 0, 0);
        push(c_K_STOP,  a + 3, 0, 0);
        push(c_K_DONE,  a + 4, 0, 0);
        wait_idle("after_reset");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
